// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared state encoding and default sizing for the correlation sequencer
package calc_pkg;

  localparam int NUM_WIN_DEF = 4;
  localparam int WLEN_W_DEF  = 5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_ACC,
    S_TERM,
    S_LOAD,
    S_PRES,
    S_ADV,
    S_DONE
  } calc_state_e;

endpackage

// File: rtl/calc_win_counter.sv
// rtl/calc_win_counter.sv - sample-within-window and window counters for one run
module calc_win_counter
  import calc_pkg::*;
#(
  parameter int NUM_WIN = NUM_WIN_DEF,
  parameter int WLEN_W  = WLEN_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  input  logic              clr,
  input  logic [WLEN_W-1:0] len,
  output logic              last_sample,
  output logic              last_win,
  output logic              first_sample
);

  localparam int WIN_W = (NUM_WIN > 1) ? $clog2(NUM_WIN) : 1;

  logic [WLEN_W-1:0] sample_q, sample_d;
  logic [WIN_W-1:0]  win_q, win_d;

  // A zero length behaves as a one-sample window.
  assign last_sample  = (len == '0) || (sample_q == len - WLEN_W'(1));
  assign last_win     = (win_q == WIN_W'(NUM_WIN - 1));
  assign first_sample = (sample_q == '0);

  always_comb begin
    sample_d = sample_q;
    win_d    = win_q;
    if (clr) begin
      sample_d = '0;
      win_d    = '0;
    end else if (inc) begin
      if (last_sample) begin
        sample_d = '0;
        win_d    = last_win ? '0 : win_q + WIN_W'(1);
      end else begin
        sample_d = sample_q + WLEN_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sample_q <= '0;
      win_q    <= '0;
    end else begin
      sample_q <= sample_d;
      win_q    <= win_d;
    end
  end

endmodule

// File: rtl/calc_seq_ctrl.sv
// rtl/calc_seq_ctrl.sv - run sequencer: clear, accumulate windows, terminate, read out results
module calc_seq_ctrl
  import calc_pkg::*;
#(
  parameter int NUM_WIN = NUM_WIN_DEF,
  parameter int WLEN_W  = WLEN_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [WLEN_W-1:0] win_len,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              acc_clr,
  output logic              acc_work,
  output logic              acc_change,
  output logic              rd_final,
  output logic              rd_next,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [1:0]        out_win,
  output logic              busy,
  output logic              done
);

  localparam logic [1:0] LAST_OUT = 2'(NUM_WIN - 1);

  calc_state_e       state_q;
  logic [WLEN_W-1:0] len_q;
  logic [1:0]        out_win_q;
  logic              live;
  logic              accept;
  logic              last_sample, last_win, first_sample;

  // Abort silences every strobe in the cycle it is seen.
  assign live   = !abort;
  assign accept = (state_q == S_ACC) && din_valid && live;

  calc_win_counter #(
    .NUM_WIN (NUM_WIN),
    .WLEN_W  (WLEN_W)
  ) u_win_counter (
    .clk          (clk),
    .rst          (rst),
    .inc          (accept),
    .clr          (state_q == S_CLEAR),
    .len          (len_q),
    .last_sample  (last_sample),
    .last_win     (last_win),
    .first_sample (first_sample)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      len_q     <= '0;
      out_win_q <= '0;
    end else if (abort && state_q != S_IDLE) begin
      state_q <= S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (start) begin
          len_q   <= win_len;
          state_q <= S_CLEAR;
        end
        S_CLEAR: begin
          out_win_q <= '0;
          state_q   <= S_ACC;
        end
        S_ACC:   if (accept && last_sample && last_win) state_q <= S_TERM;
        S_TERM:  state_q <= S_LOAD;
        S_LOAD: begin
          out_win_q <= '0;
          state_q   <= S_PRES;
        end
        S_PRES:  if (out_ready) state_q <= (out_win_q != LAST_OUT) ? S_ADV : S_DONE;
        S_ADV: begin
          out_win_q <= out_win_q + 2'd1;
          state_q   <= S_PRES;
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign din_ready  = (state_q == S_ACC) && live;
  assign acc_clr    = (state_q == S_CLEAR) && live;
  assign acc_work   = accept || ((state_q == S_TERM) && live);
  assign acc_change = (accept && first_sample) || ((state_q == S_TERM) && live);
  assign rd_final   = (state_q == S_LOAD) && live;
  assign rd_next    = (state_q == S_ADV) && live;
  assign out_valid  = (state_q == S_PRES) && live;
  assign out_win    = out_win_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE) && live;

endmodule

// File: tb/tb_calc_seq_ctrl.sv
// tb/tb_calc_seq_ctrl.sv - directed self-checking bench for calc_seq_ctrl
module tb_calc_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst, start, abort, din_valid, out_ready;
  logic [4:0] win_len;
  logic       din_ready, acc_clr, acc_work, acc_change, rd_final, rd_next;
  logic       out_valid, busy, done;
  logic [1:0] out_win;

  int checks = 0;
  int failures = 0;

  // Per-run event record, restarted whenever acc_clr is seen.
  int r_work = 0, r_mask = 0, r_final = 0, r_next = 0, r_done = 0;
  int r_hs = 0, r_seq = 0, r_ovl = 0, r_bad = 0;
  int stall_n, stall_bad;

  always #5 clk = ~clk;

  calc_seq_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .win_len(win_len),
    .din_valid(din_valid), .din_ready(din_ready), .acc_clr(acc_clr),
    .acc_work(acc_work), .acc_change(acc_change), .rd_final(rd_final),
    .rd_next(rd_next), .out_valid(out_valid), .out_ready(out_ready),
    .out_win(out_win), .busy(busy), .done(done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (acc_clr) begin
      r_work = 0; r_mask = 0; r_final = 0; r_next = 0; r_done = 0;
      r_hs = 0; r_seq = 0; r_ovl = 0; r_bad = 0;
    end
    if (acc_work) begin
      if (acc_change) r_mask = r_mask | (32'd1 << r_work);
      if (din_ready && !din_valid) r_bad++;
      r_work++;
    end
    if (acc_change && !acc_work) r_bad++;
    if (rd_final) r_final++;
    if (rd_next) r_next++;
    if (done) r_done++;
    if (out_valid && out_ready) begin
      r_seq = (r_seq << 2) | int'(out_win);
      r_hs++;
    end
    if (int'(acc_clr) + int'(acc_work) + int'(rd_final) + int'(rd_next) > 1) r_ovl++;
  end

  task automatic do_run(input logic [4:0] len, input bit gaps, input bit stall);
    stall_n = 0;
    stall_bad = 0;
    win_len = len;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 300 && !(c > 0 && r_done > 0); c++) begin
      din_valid = gaps ? (c % 2 == 0) : 1'b1;
      out_ready = !(stall && out_valid && out_win == 2'd1 && stall_n < 5);
      @(negedge clk);
      if (stall && out_valid && !out_ready) begin
        stall_n++;
        if (out_win != 2'd1 || rd_next) stall_bad++;
      end
      @(posedge clk); #1;
    end
    check("run_done_seen", 32'(r_done), 32'd1);
    din_valid = 1'b0;
    out_ready = 1'b1;
  endtask

  initial begin
    int seen;
    rst = 1'b1; start = 1'b0; abort = 1'b0; din_valid = 1'b0;
    out_ready = 1'b1; win_len = '0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("reset_outputs", 32'({din_ready, acc_clr, acc_work, acc_change, rd_final,
                                rd_next, out_valid, busy, done, out_win}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    do_run(5'd3, 1'b0, 1'b0);
    check("l3_work", 32'(r_work), 32'd13);
    check("l3_change_mask", 32'(r_mask), 32'h1249);
    check("l3_rd_final", 32'(r_final), 32'd1);
    check("l3_rd_next", 32'(r_next), 32'd3);
    check("l3_win_seq", 32'(r_seq), 32'h1B);
    check("l3_handshakes", 32'(r_hs), 32'd4);
    check("l3_overlap", 32'(r_ovl), 32'd0);
    check("l3_bad", 32'(r_bad), 32'd0);
    check("l3_idle_after", 32'(busy), 32'd0);

    do_run(5'd0, 1'b0, 1'b0);
    check("l0_work", 32'(r_work), 32'd5);
    check("l0_change_mask", 32'(r_mask), 32'h1F);

    do_run(5'd2, 1'b1, 1'b0);
    check("gap_work", 32'(r_work), 32'd9);
    check("gap_change_mask", 32'(r_mask), 32'h155);
    check("gap_bad", 32'(r_bad), 32'd0);
    check("gap_overlap", 32'(r_ovl), 32'd0);

    do_run(5'd1, 1'b0, 1'b1);
    check("stall_cycles", 32'(stall_n), 32'd5);
    check("stall_unstable", 32'(stall_bad), 32'd0);
    check("stall_rd_next", 32'(r_next), 32'd3);
    check("stall_win_seq", 32'(r_seq), 32'h1B);

    // Abort after the fifth accepted sample.
    win_len = 5'd3;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    din_valid = 1'b1;
    seen = 0;
    for (int c = 0; c < 50 && seen < 5; c++) begin
      @(negedge clk);
      if (acc_work) seen++;
      @(posedge clk); #1;
    end
    check("abort_samples", 32'(seen), 32'd5);
    abort = 1'b1;
    @(negedge clk);
    check("abort_suppress", 32'({acc_work, acc_change, din_ready}), 32'd0);
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    check("abort_idle", 32'({busy, din_ready}), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("abort_no_done", 32'(r_done), 32'd0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("abort_restart_clr", 32'({acc_clr, busy}), 32'b11);

    // Park in PRES window 0 and apply reset there.
    out_ready = 1'b0;
    seen = 0;
    for (int c = 0; c < 100 && !out_valid; c++) begin
      @(posedge clk); #1;
    end
    check("pres_reached", 32'({out_valid, out_win}), 32'b100);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("start_ignored", 32'({out_valid, acc_clr, busy, out_win}), 32'b10100);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("reset_in_pres", 32'({din_ready, acc_clr, acc_work, acc_change, rd_final,
                                rd_next, out_valid, busy, done, out_win}), 32'd0);

    do_run(5'd1, 1'b0, 1'b0);
    check("post_reset_work", 32'(r_work), 32'd5);
    check("post_reset_seq", 32'(r_seq), 32'h1B);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
